// File: rtl/serial_add.sv
// serial_add: bit-serial add/sub, LSB first, one full-add cell; in clk, reset_n, start, sub, cin, a, b; out busy, done, s, cout, plus ovf when SERIAL_ADD_OVF_EN is defined
module serial_add #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t state;
    logic [WIDTH-1:0] ra, rb;
    logic [CW-1:0] cnt;
    logic sub_q, carry, bx, sum, maj;
    assign bx  = rb[0] ^ sub_q;
    assign sum = ra[0] ^ bx ^ carry;
    assign maj = (ra[0] & bx) | (ra[0] & carry) | (bx & carry);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
            ra    <= '0;
            rb    <= '0;
            cnt   <= '0;
            sub_q <= 1'b0;
            carry <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (state == S_RUN) begin
            ra    <= {sum, ra[WIDTH-1:1]};
            rb    <= rb >> 1;
            carry <= maj;
            cnt   <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                s     <= {sum, ra[WIDTH-1:1]};
                cout  <= maj;
`ifdef SERIAL_ADD_OVF_EN
                ovf   <= carry ^ maj;
`endif
            end
        end else if (start) begin
            state <= S_RUN;
            busy  <= 1'b1;
            done  <= 1'b0;
            ra    <= a;
            rb    <= b;
            sub_q <= sub;
            carry <= cin ^ sub;
            cnt   <= '0;
        end else begin
            state <= S_IDLE;
            done  <= 1'b0;
        end
    end
endmodule

// File: doc/serial_add.md
SERIAL_ADD -- requirements
Module: serial_add

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the operand and result width in bits (legal values 2..32).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request a new operation.
REQ-005 SHALL have port sub, input, 1 bit: 0 selects a+b+cin, 1 selects a-b-cin; sampled with start.
REQ-006 SHALL have port cin, input, 1 bit: carry-in (add) or borrow-in (sub); sampled with start.
REQ-007 SHALL have port a, input, WIDTH bits: operand A; sampled with start.
REQ-008 SHALL have port b, input, WIDTH bits: operand B; sampled with start.
REQ-009 SHALL have port busy, output, 1 bit: high while bits are being processed.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when s/cout become valid.
REQ-011 SHALL have port s, output, WIDTH bits: the result.
REQ-012 SHALL have port cout, output, 1 bit: final carry; in subtract mode 1 means no borrow.
REQ-013 SHALL have port ovf, output, 1 bit: signed overflow; present only per REQ-030.

Function
REQ-014 SHALL implement an FSM with three states:
- IDLE: busy=0, done=0.
- RUN: busy=1, done=0.
- DONE: busy=0, done=1.
REQ-015 SHALL accept start only in IDLE or DONE, with these actions on acceptance:
- load the A and B shift registers;
- latch sub;
- set carry flop = cin XOR sub;
- clear the bit counter;
- go to RUN.
REQ-016 SHALL, in RUN, process one bit per cycle, LSB first, using a single 1-bit full-add cell:
- sum bit = a0 ^ (b0 ^ sub) ^ carry;
- carry <= majority(a0, b0 ^ sub, carry).
REQ-017 SHALL, in RUN, shift the sum bit into the MSB of the result register and shift the operand registers right by one.
REQ-018 SHALL leave RUN for DONE after exactly WIDTH RUN cycles, and go from DONE to IDLE after one cycle unless start is accepted.
REQ-019 SHALL assert done in the cycle after the WIDTH-th RUN edge, i.e. WIDTH+1 rising edges after the edge that sampled start.
REQ-020 SHALL drive s and cout from holding registers that update only on the DONE transition and hold until the next DONE; they SHALL NOT show partial results while RUN is in progress.
REQ-021 SHALL ignore start while in RUN, and SHALL NOT disturb the operation in progress.
REQ-022 SHALL, when start is accepted in the DONE cycle, still present the completed result in s/cout, with the new operation going to RUN on the same edge (back-to-back throughput of one result per WIDTH+1 cycles).
REQ-023 SHALL have no internal state that reads a, b, sub or cin outside the start-acceptance edge; these inputs may change freely during RUN.
REQ-024 SHALL size the bit counter to ceil(log2(WIDTH+1)) bits with no wrap before WIDTH.

Reset
REQ-025 SHALL, on reset_n low, immediately and asynchronously force:
- state = IDLE;
- busy = 0, done = 0;
- s = 0, cout = 0, ovf = 0;
- carry, counter and shift registers = 0.
REQ-026 SHALL, on reset assertion mid-RUN, abandon the operation and produce no done pulse.
REQ-027 SHALL deassert reset as an ordinary event: the first rising edge with reset_n high may accept start.

Configuration
REQ-028 SHALL use the macro SERIAL_ADD_OVF_EN to compile the signed-overflow feature in or out.
REQ-029 SHALL, with SERIAL_ADD_OVF_EN defined, latch the carry into the MSB position during the final RUN cycle, and register ovf = carry_into_msb XOR carry_out_of_msb, updated alongside s/cout.
REQ-030 SHALL, without SERIAL_ADD_OVF_EN, have no ovf port and no associated logic.

Verification
REQ-031 SHALL cover WIDTH=8 add: a=0x0F, b=0x01, sub=0, cin=0 -> done 9 edges after start, s=0x10, cout=0.
REQ-032 SHALL cover wrap-around add: a=0xFF, b=0x01, cin=0 -> s=0x00, cout=1; a=0xFF, b=0x00, cin=1 -> s=0x00, cout=1.
REQ-033 SHALL cover subtract: a=0x05, b=0x07, sub=1, cin=0 -> s=0xFE, cout=0; a=0x07, b=0x05, sub=1, cin=1 -> s=0x01, cout=1.
REQ-034 SHALL cover busy protection: start pulsed with a=0x11 at RUN cycle 3 of 0x0F+0x01 -> result still 0x10, and exactly one done pulse.
REQ-035 SHALL cover reset mid-op: reset_n low at RUN cycle 4 -> all outputs 0 immediately, no done pulse; a new start after release yields the correct result.
REQ-036 SHALL cover overflow with SERIAL_ADD_OVF_EN defined: a=0x7F, b=0x01, sub=0 -> s=0x80, ovf=1; a=0x80, b=0x01, sub=1 -> s=0x7F, ovf=1.
